// File: rtl/rst_wake_pkg.sv
// Shared types for the board-input reset/wakeup conditioner.
// Holds the sequencer state encoding, the reset-cause codes and the cause decode helper.
package rst_wake_pkg;

  typedef enum logic [1:0] {
    RST_ACTIVE = 2'd0,
    RST_HOLD   = 2'd1,
    RUN        = 2'd2
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_FPGA = 2'b01;
  localparam logic [1:0] CAUSE_MCU  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  // Inputs are the filtered active-low reset levels seen on the cycle RUN is left.
  function automatic logic [1:0] reset_cause(input logic fpga_ok, input logic mcu_ok);
    if (!fpga_ok && !mcu_ok) return CAUSE_BOTH;
    else if (!fpga_ok)       return CAUSE_FPGA;
    else if (!mcu_ok)        return CAUSE_MCU;
    else                     return CAUSE_POR;
  endfunction

endpackage

// File: rtl/rst_wake_cond_debounce_filter.sv
// Two-flop synchroniser followed by a stability counter for one raw board pad.
// The filtered level follows the pad only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_filter #(
  parameter int   DEBOUNCE_CYCLES = 16000,
  parameter logic INIT            = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic filtered
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] count;

  // The terminal-count compare also bounds the counter, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1  <= INIT;
      sync_q2  <= INIT;
      filtered <= INIT;
      count    <= '0;
    end else begin
      sync_q1 <= pad;
      sync_q2 <= sync_q1;
      if (sync_q2 == filtered) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        filtered <= sync_q2;
        count    <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_wake_cond.sv
// Conditions the FPGA/MCU reset and wakeup pads into a glitch-free system reset,
// a debounced wakeup level with press strobe, and a record of the last reset cause.
module rst_wake_cond
  import rst_wake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int HOLD_CYCLES     = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fpga_rst_n_pad,
  input  logic       mcu_rst_n_pad,
  input  logic       wakeup_pad,
  output logic       sys_rst_n,
  output logic       wakeup_n,
  output logic       wake_pulse,
  output logic [1:0] rst_cause,
  output logic       seq_busy
);

  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          fpga_ok;
  logic          mcu_ok;
  logic          wake_level;
  logic          wake_prev;
  logic          resets_released;
  seq_state_e    state;
  logic [HW-1:0] hold_count;
  logic [1:0]    cause_q;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)) u_fpga_filter (
    .clk      (clk),
    .reset    (reset),
    .pad      (fpga_rst_n_pad),
    .filtered (fpga_ok)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)) u_mcu_filter (
    .clk      (clk),
    .reset    (reset),
    .pad      (mcu_rst_n_pad),
    .filtered (mcu_ok)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)) u_wake_filter (
    .clk      (clk),
    .reset    (reset),
    .pad      (wakeup_pad),
    .filtered (wake_level)
  );

  assign resets_released = fpga_ok & mcu_ok;

  // A reset dropping during the hold aborts it before completion is considered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RST_ACTIVE;
      hold_count <= '0;
      cause_q    <= CAUSE_POR;
    end else begin
      case (state)
        RST_ACTIVE: begin
          if (resets_released) begin
            state      <= RST_HOLD;
            hold_count <= '0;
          end
        end
        RST_HOLD: begin
          if (!resets_released) begin
            state      <= RST_ACTIVE;
            hold_count <= '0;
          end else if (hold_count == HOLD_LAST) begin
            state <= RUN;
          end else begin
            hold_count <= hold_count + 1'b1;
          end
        end
        RUN: begin
          if (!resets_released) begin
            state   <= RST_ACTIVE;
            cause_q <= reset_cause(fpga_ok, mcu_ok);
          end
        end
        default: begin
          state      <= RST_ACTIVE;
          hold_count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wake_prev <= 1'b0;
    else       wake_prev <= wake_level;
  end

  // Outputs decode flops only, so the reset line cannot glitch on input activity.
  assign sys_rst_n  = (state == RUN);
  assign seq_busy   = (state == RST_HOLD);
  assign wakeup_n   = ~wake_level;
  assign wake_pulse = wake_level & ~wake_prev & (state == RUN);
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_wake_cond.sv
// Directed and randomised bench for rst_wake_cond with a short debounce and hold.
// A behavioural model built on sample windows and run lengths predicts every output each cycle.
module tb_rst_wake_cond;

  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       fpga_rst_n_pad = 1'b1;
  logic       mcu_rst_n_pad  = 1'b1;
  logic       wakeup_pad     = 1'b0;
  logic       sys_rst_n;
  logic       wakeup_n;
  logic       wake_pulse;
  logic [1:0] rst_cause;
  logic       seq_busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int busy_cnt  = 0;
  int pulse_cnt = 0;

  logic [D+1:0] h_fpga, h_mcu, h_wake;
  logic         m_fpga, m_mcu, m_wake, m_wake_prev;
  logic [1:0]   m_cause;
  int           m_streak;

  rst_wake_cond #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk            (clk),
    .reset          (reset),
    .fpga_rst_n_pad (fpga_rst_n_pad),
    .mcu_rst_n_pad  (mcu_rst_n_pad),
    .wakeup_pad     (wakeup_pad),
    .sys_rst_n      (sys_rst_n),
    .wakeup_n       (wakeup_n),
    .wake_pulse     (wake_pulse),
    .rst_cause      (rst_cause),
    .seq_busy       (seq_busy)
  );

  always #5 clk = ~clk;

  // h[0] is the newest pad sample; h[2] is what the synchroniser presents this edge.
  function automatic logic filt_next(input logic [D+1:0] h, input logic f);
    for (int k = 2; k <= D + 1; k++)
      if (h[k] == f) return f;
    return ~f;
  endfunction

  task automatic model_reset();
    h_fpga = '0; h_mcu = '0; h_wake = '0;
    m_fpga = 1'b0; m_mcu = 1'b0; m_wake = 1'b0; m_wake_prev = 1'b0;
    m_cause = 2'b00;
    m_streak = 0;
  endtask

  // m_streak counts edges the sequencer has seen both resets released: 0 idle, 1..H hold, above H run.
  task automatic model_edge();
    logic old_fpga, old_mcu;
    old_fpga = m_fpga;
    old_mcu  = m_mcu;
    h_fpga = {h_fpga[D:0], fpga_rst_n_pad};
    h_mcu  = {h_mcu[D:0],  mcu_rst_n_pad};
    h_wake = {h_wake[D:0], wakeup_pad};
    m_fpga = filt_next(h_fpga, m_fpga);
    m_mcu  = filt_next(h_mcu,  m_mcu);
    m_wake_prev = m_wake;
    m_wake = filt_next(h_wake, m_wake);
    if (!(old_fpga && old_mcu)) begin
      if (m_streak > H) begin
        if (!old_fpga && !old_mcu) m_cause = 2'b11;
        else if (!old_fpga)        m_cause = 2'b01;
        else                       m_cause = 2'b10;
      end
      m_streak = 0;
    end else if (m_streak <= H) begin
      m_streak++;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [1:0] exp_cause;
    exp_cause = m_cause;
    check_bit({tag, ".sys_rst_n"}, sys_rst_n, m_streak > H);
    check_bit({tag, ".seq_busy"}, seq_busy, (m_streak >= 1) && (m_streak <= H));
    check_bit({tag, ".wakeup_n"}, wakeup_n, ~m_wake);
    check_bit({tag, ".wake_pulse"}, wake_pulse, m_wake && !m_wake_prev && (m_streak > H));
    n_checks++;
    assert (rst_cause === exp_cause) else begin
      n_fail++;
      $error("[TB] FAIL %s.rst_cause observed=%b expected=%b", tag, rst_cause, exp_cause);
    end
  endtask

  task automatic apply_stimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      model_edge();
      #1;
      check_output("cycle");
      busy_cnt  += int'(seq_busy === 1'b1);
      pulse_cnt += int'(wake_pulse === 1'b1);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 check_output("async_reset");
    #1 reset = 1'b0;
  endtask

  task automatic edges_until_rst_n(input logic level, input int limit, output int count);
    count = 0;
    do begin
      apply_stimulus(1);
      count++;
    end while (sys_rst_n !== level && count < limit);
  endtask

  task automatic wait_hold_entry();
    int c;
    c = 0;
    do begin
      apply_stimulus(1);
      c++;
    end while (seq_busy !== 1'b1 && c < 40);
    check_bit("hold_entry", seq_busy, 1'b1);
  endtask

  task automatic edges_until_wake(input int limit, output int count);
    count = 0;
    do begin
      apply_stimulus(1);
      count++;
    end while (wakeup_n !== 1'b0 && count < limit);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_output("reset_state");

    $display("[TB] power-up release");
    @(negedge clk);
    reset = 1'b0;
    busy_cnt = 0;
    edges_until_rst_n(1'b1, 40, c);
    check_int("powerup_latency", c, 2 + D + 1 + H);
    check_int("powerup_busy_cycles", busy_cnt, H);
    check_int("powerup_cause", int'(rst_cause), 0);

    $display("[TB] async reset in the middle of the hold");
    pulse_reset();
    wait_hold_entry();
    apply_stimulus(6);
    pulse_reset();
    check_bit("mid_hold_rst_n", sys_rst_n, 1'b0);
    check_bit("mid_hold_busy", seq_busy, 1'b0);
    edges_until_rst_n(1'b1, 40, c);
    check_int("mid_hold_relaunch", c, 2 + D + 1 + H);

    // MCU pad falls as the hold begins, so its filtered drop lands while still holding.
    $display("[TB] hold abort");
    pulse_reset();
    wait_hold_entry();
    mcu_rst_n_pad = 1'b0;
    apply_stimulus(6);
    mcu_rst_n_pad = 1'b1;
    apply_stimulus(1);
    check_bit("abort_busy", seq_busy, 1'b0);
    check_bit("abort_rst_n", sys_rst_n, 1'b0);
    check_int("abort_cause", int'(rst_cause), 0);
    edges_until_rst_n(1'b1, 40, c);
    check_int("abort_relaunch", c + 1, 2 + D + 1 + H);

    $display("[TB] glitch rejection");
    apply_stimulus(3);
    fpga_rst_n_pad = 1'b0;
    apply_stimulus(D - 1);
    fpga_rst_n_pad = 1'b1;
    apply_stimulus(12);
    check_bit("glitch_rst_n", sys_rst_n, 1'b1);
    check_int("glitch_cause", int'(rst_cause), 0);
    fpga_rst_n_pad = 1'b0;
    c = 0;
    do begin
      apply_stimulus(1);
      c++;
      if (c == D) fpga_rst_n_pad = 1'b1;
    end while (sys_rst_n !== 1'b0 && c < 20);
    check_int("fpga_assert_latency", c, 2 + D + 1);
    check_int("fpga_cause", int'(rst_cause), 1);
    edges_until_rst_n(1'b1, 40, c);

    $display("[TB] simultaneous resets");
    apply_stimulus(3);
    fpga_rst_n_pad = 1'b0;
    mcu_rst_n_pad  = 1'b0;
    apply_stimulus(10);
    check_int("both_cause", int'(rst_cause), 3);
    fpga_rst_n_pad = 1'b1;
    mcu_rst_n_pad  = 1'b1;
    edges_until_rst_n(1'b1, 40, c);
    check_int("both_release_latency", c, 2 + D + 1 + H);

    $display("[TB] wakeup while running");
    pulse_cnt = 0;
    wakeup_pad = 1'b1;
    edges_until_wake(20, c);
    check_int("wake_run_latency", c, 2 + D);
    apply_stimulus(20 - c);
    wakeup_pad = 1'b0;
    apply_stimulus(10);
    check_int("wake_run_pulses", pulse_cnt, 1);

    $display("[TB] wakeup while held in reset");
    fpga_rst_n_pad = 1'b0;
    apply_stimulus(10);
    pulse_cnt = 0;
    wakeup_pad = 1'b1;
    edges_until_wake(20, c);
    check_int("wake_active_latency", c, 2 + D);
    apply_stimulus(20 - c);
    wakeup_pad = 1'b0;
    apply_stimulus(10);
    check_int("wake_active_pulses", pulse_cnt, 0);
    fpga_rst_n_pad = 1'b1;
    edges_until_rst_n(1'b1, 40, c);

    $display("[TB] randomised pad activity");
    for (int seg = 0; seg < 300; seg++) begin
      fpga_rst_n_pad = ($urandom_range(0, 5) != 0);
      mcu_rst_n_pad  = ($urandom_range(0, 5) != 0);
      wakeup_pad     = 1'($urandom_range(0, 1));
      if (fpga_rst_n_pad && mcu_rst_n_pad) apply_stimulus(int'($urandom_range(5, 30)));
      else                                 apply_stimulus(int'($urandom_range(1, 8)));
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
